pipe_mem_stage: RTL and testbench

//  Consumer end of the EX/MEM register: MEM stage of the 5-stage pipeline CPU.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_mem_stage_if.sv | 18 +
 rtl/pipe_mem_stage_mwreg.sv | 73 +++++++
 rtl/pipe_mem_stage.sv | 147 ++++++++++++++
 tb/tb_pipe_mem_stage.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared MEM-stage definitions: FSM state encoding, default widths, bubble control.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // {wreg, m2reg} forced into MEM/WB when a bubble is inserted
  localparam logic [1:0] BUBBLE = 2'b00;

  // Wait-counter width; at least one bit so TIMEOUT=0 still elaborates
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/pipe_mem_stage_if.sv
// Data-memory request/acknowledge port between the MEM stage and data memory.
// Latency: n/a (signal bundle only).
// Backpressure: requester holds req/we/addr/wdata until ack.
interface pipe_mem_stage_if
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic          dm_req;
  logic          dm_we;
  logic [DW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_wdata, input dm_ack, dm_rdata);
  modport slave  (input dm_req, dm_we, dm_addr, dm_wdata, output dm_ack, dm_rdata);
endinterface

// File: rtl/pipe_mem_stage_mwreg.sv
// MEM/WB pipeline register with load and bubble controls.
// Latency: 1 cycle from load to W outputs.
// Backpressure: load=0,bubble=1 kills wreg/m2reg and holds data fields.
module pipemwreg
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          load,
  input  logic          bubble,
  input  logic          wreg_in,
  input  logic          m2reg_in,
  input  logic [DW-1:0] mo_in,
  input  logic [DW-1:0] alu_in,
  input  logic [RW-1:0] rn_in,
  output logic          wwreg,
  output logic          wm2reg,
  output logic [DW-1:0] wmo,
  output logic [DW-1:0] walu,
  output logic [RW-1:0] wrn
);

  logic          wwreg_q,  wwreg_d;
  logic          wm2reg_q, wm2reg_d;
  logic [DW-1:0] wmo_q,    wmo_d;
  logic [DW-1:0] walu_q,   walu_d;
  logic [RW-1:0] wrn_q,    wrn_d;

  // Next W contents: load takes priority, bubble clears only the control bits
  always_comb begin
    wwreg_d  = wwreg_q;
    wm2reg_d = wm2reg_q;
    wmo_d    = wmo_q;
    walu_d   = walu_q;
    wrn_d    = wrn_q;
    if (load) begin
      wwreg_d  = wreg_in;
      wm2reg_d = m2reg_in;
      wmo_d    = mo_in;
      walu_d   = alu_in;
      wrn_d    = rn_in;
    end else if (bubble) begin
      {wwreg_d, wm2reg_d} = BUBBLE;
    end
  end

  // W-stage state register, cleared asynchronously
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wmo_q    <= '0;
      walu_q   <= '0;
      wrn_q    <= '0;
    end else begin
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      wrn_q    <= wrn_d;
    end
  end

  assign wwreg  = wwreg_q;
  assign wm2reg = wm2reg_q;
  assign wmo    = wmo_q;
  assign walu   = walu_q;
  assign wrn    = wrn_q;

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: issues loads/stores on the req/ack port and fills the MEM/WB register.
// Latency: non-memory ops 1 cycle; memory ops 1 issue + 1..TIMEOUT wait + 1 DONE cycle.
// Backpressure: mem_stall holds upstream stages until the access reaches DONE.
module pipe_mem_stage
  import pipe_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int RW      = RW_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    mwreg,
  input  logic                    mm2reg,
  input  logic                    mwmem,
  input  logic [DW-1:0]           malu,
  input  logic [DW-1:0]           mb,
  input  logic [RW-1:0]           mrn,
  pipe_mem_stage_if.master        dm,
  output logic                    mem_stall,
  output logic                    mem_err,
  output logic                    wwreg,
  output logic                    wm2reg,
  output logic [DW-1:0]           wmo,
  output logic [DW-1:0]           walu,
  output logic [RW-1:0]           wrn
);

  localparam int            CW      = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_CNT  = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic          req_q,   req_d;
  logic          we_q,    we_d;
  logic [DW-1:0] addr_q,  addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] buf_q,   buf_d;
  logic          err_q,   err_d;

  logic          memop;
  logic [CW-1:0] cnt_inc;
  logic          wb_load;
  logic          wb_m2reg;
  logic [DW-1:0] wb_mo;

  assign memop   = mwmem | mm2reg;
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  // Access FSM: issue in IDLE, wait for ack or timeout in BUSY, retire in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          state_d = BUSY;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = mwmem;
          addr_d  = {malu[DW-1:2], 2'b00};
          wdata_d = mb;
        end
      end
      BUSY: begin
        if (dm.dm_ack) begin
          state_d = DONE;
          req_d   = 1'b0;
          buf_d   = dm.dm_rdata;
        end else begin
          cnt_d = cnt_inc;
          if (TIMEOUT != 0 && cnt_inc == TO_CNT) begin
            // Abort so the pipeline cannot hang on a dead memory
            state_d = DONE;
            req_d   = 1'b0;
            err_d   = 1'b1;
            buf_d   = '0;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM, counter and memory-port registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // MEM/WB control: load on a plain op or on retire, bubble otherwise
  always_comb begin
    mem_stall = memop & (state_q != DONE);
    wb_load   = ((state_q == IDLE) & ~memop) | (state_q == DONE);
    wb_m2reg  = (state_q == DONE) & mm2reg & ~mwmem;
    wb_mo     = (state_q == DONE) ? buf_q : '0;
  end

  pipemwreg #(.DW(DW), .RW(RW)) u_mwreg (
    .clock    (clock),
    .resetn   (resetn),
    .load     (wb_load),
    .bubble   (~wb_load),
    .wreg_in  (mwreg),
    .m2reg_in (wb_m2reg),
    .mo_in    (wb_mo),
    .alu_in   (malu),
    .rn_in    (mrn),
    .wwreg    (wwreg),
    .wm2reg   (wm2reg),
    .wmo      (wmo),
    .walu     (walu),
    .wrn      (wrn)
  );

  assign dm.dm_req   = req_q;
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_wdata = wdata_q;
  assign mem_err     = err_q;

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Self-checking bench for pipe_mem_stage: directed scenarios plus random instruction mix.
// Latency: n/a.
// Backpressure: upstream inputs held while mem_stall is high.
module tb_pipe_mem_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        resetn;
  logic        mwreg, mm2reg, mwmem;
  logic [31:0] malu, mb;
  logic [4:0]  mrn;
  logic        mem_stall, mem_err, wwreg, wm2reg;
  logic [31:0] wmo, walu;
  logic [4:0]  wrn;

  pipe_mem_stage_if #(.DW(32)) dm_if ();

  pipe_mem_stage #(.DW(32), .RW(5), .TIMEOUT(TO)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .mwreg     (mwreg),
    .mm2reg    (mm2reg),
    .mwmem     (mwmem),
    .malu      (malu),
    .mb        (mb),
    .mrn       (mrn),
    .dm        (dm_if),
    .mem_stall (mem_stall),
    .mem_err   (mem_err),
    .wwreg     (wwreg),
    .wm2reg    (wm2reg),
    .wmo       (wmo),
    .walu      (walu),
    .wrn       (wrn)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference state: sticky error flag and last retired ALU value (held across bubbles)
  logic        m_err;
  logic [31:0] m_alu;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Present one instruction at a negedge, emulate memory, and check its whole life.
  // ack_at: BUSY cycle (1-based) in which memory acks; 0 or > TO means never in time.
  task automatic run_instr(input logic wr, input logic m2r, input logic wm,
                           input logic [31:0] alu, input logic [31:0] b,
                           input logic [4:0] rn, input int ack_at,
                           input logic [31:0] rdata);
    bit          memop, tmo, done;
    int          busy, stalls, reqc, exp_stalls;
    logic [31:0] exp_mo;
    memop      = wm | m2r;
    tmo        = memop && !(ack_at >= 1 && ack_at <= TO);
    busy       = !memop ? 0 : (tmo ? TO : ack_at);
    exp_stalls = memop ? busy + 1 : 0;
    exp_mo     = (!memop || tmo) ? 32'h0 : rdata;

    mwreg = wr; mm2reg = m2r; mwmem = wm; malu = alu; mb = b; mrn = rn;
    stalls = 0; reqc = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      if (c == 0) check("req_idle_at_issue", 64'(dm_if.dm_req), 64'(0));
      if (c > 0) begin
        check("bubble_wwreg", 64'(wwreg), 64'(0));
        check("bubble_wm2reg", 64'(wm2reg), 64'(0));
        check("bubble_walu_hold", 64'(walu), 64'(m_alu));
      end
      if (dm_if.dm_req) begin
        reqc++;
        check("dm_addr", 64'(dm_if.dm_addr), 64'(alu & 32'hFFFF_FFFC));
        check("dm_we", 64'(dm_if.dm_we), 64'(wm));
        if (wm) check("dm_wdata", 64'(dm_if.dm_wdata), 64'(b));
        dm_if.dm_ack   = (reqc == ack_at);
        dm_if.dm_rdata = dm_if.dm_ack ? rdata : $urandom;
      end else begin
        // stray acks while no request is outstanding must be ignored
        dm_if.dm_ack   = ($urandom_range(0, 3) == 0);
        dm_if.dm_rdata = $urandom;
      end
      #1;
      if (mem_stall) stalls++;
      else done = 1;
      @(negedge clock);
    end
    dm_if.dm_ack = 1'b0;
    check("retired_within_bound", 64'(done), 64'(1));
    check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    check("req_cycles", 64'(reqc), 64'(busy));
    m_err = m_err | tmo;
    m_alu = alu;
    check("wwreg", 64'(wwreg), 64'(wr));
    check("wm2reg", 64'(wm2reg), 64'(memop & m2r & ~wm));
    check("wmo", 64'(wmo), 64'(exp_mo));
    check("walu", 64'(walu), 64'(alu));
    check("wrn", 64'(wrn), 64'(rn));
    check("mem_err", 64'(mem_err), 64'(m_err));
  endtask

  task automatic run_random(input int n, input bit allow_timeout);
    int kind, ack;
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(0, 3);
      ack  = allow_timeout ? $urandom_range(0, TO + 2) : $urandom_range(1, TO);
      run_instr(1'($urandom), kind == 1 || kind == 3, kind == 2 || kind == 3,
                $urandom, $urandom, 5'($urandom), ack, $urandom);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dm_req"}, 64'(dm_if.dm_req), 64'(0));
    check({tag, "_wwreg"}, 64'(wwreg), 64'(0));
    check({tag, "_wm2reg"}, 64'(wm2reg), 64'(0));
    check({tag, "_wmo"}, 64'(wmo), 64'(0));
    check({tag, "_walu"}, 64'(walu), 64'(0));
    check({tag, "_wrn"}, 64'(wrn), 64'(0));
    check({tag, "_mem_err"}, 64'(mem_err), 64'(0));
  endtask

  initial begin
    resetn = 1'b0;
    mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
    dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
    m_err = 1'b0; m_alu = '0;

    @(negedge clock); #1;
    check_reset_outputs("reset");
    check("reset_dm_we", 64'(dm_if.dm_we), 64'(0));
    check("reset_dm_addr", 64'(dm_if.dm_addr), 64'(0));
    check("reset_dm_wdata", 64'(dm_if.dm_wdata), 64'(0));
    @(negedge clock);
    resetn = 1'b1;

    // ALU op, load with late ack, store acked in first BUSY cycle
    run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 32'h103, 32'h0, 5'd9, 3, 32'hDEADBEEF);
    run_instr(1'b0, 1'b0, 1'b1, 32'h40, 32'h55, 5'd0, 1, 32'h0BAD_F00D);
    // back-to-back load then store, then both flags set (store wins)
    run_instr(1'b1, 1'b1, 1'b0, 32'h2006, 32'h0, 5'd3, 2, 32'hCAFE_0001);
    run_instr(1'b0, 1'b0, 1'b1, 32'h2008, 32'h7777, 5'd4, 4, 32'h1111_2222);
    run_instr(1'b1, 1'b1, 1'b1, 32'h300B, 32'h9999, 5'd6, 2, 32'h3333_4444);

    run_random(30, 1'b0);

    // load that never gets acked: abort after TO cycles, error flag sticks
    run_instr(1'b1, 1'b1, 1'b0, 32'h500, 32'h0, 5'd12, 0, 32'hFFFF_FFFF);
    run_instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 5'd13, 0, 32'h0);

    run_random(30, 1'b1);

    // reset in the middle of an outstanding load
    mwreg = 1; mm2reg = 1; mwmem = 0; malu = 32'h8000_0010; mrn = 5'd7;
    @(negedge clock);
    check("mid_access_req", 64'(dm_if.dm_req), 64'(1));
    #2 resetn = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clock);
    mwreg = 0; mm2reg = 0; mwmem = 0; malu = '0; mb = '0; mrn = '0;
    dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'hBADC_0DE5;
    resetn = 1'b1;
    @(negedge clock);
    check("late_ack_req", 64'(dm_if.dm_req), 64'(0));
    check("late_ack_stall", 64'(mem_stall), 64'(0));
    check("late_ack_wmo", 64'(wmo), 64'(0));
    dm_if.dm_ack = 1'b0;
    m_err = 1'b0; m_alu = '0;
    run_instr(1'b1, 1'b0, 1'b0, 32'hA5A5, 32'h0, 5'd21, 0, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 32'hC01, 32'h0, 5'd22, 2, 32'h1357_9BDF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
